nco_phase_gen: RTL

- Sample-rate NCO front end that sits directly upstream of the 16-bit CORDIC rotator.
- Runs a programmable phase accumulator and adds a phase offset plus optional LFSR dither. On each sample tick it drives the rotator's phase, X/Y seed vector and clock-enable.
- Frequency, offset, amplitude and rate-divider are loaded through a valid/ready handshake. They are double-buffered and applied coherently on a sample boundary.

---
 rtl/nco_phase_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nco_phase_gen.sv
// NCO front end: phase accumulator + offset + LFSR dither feeding the CORDIC rotator; outputs register one cycle after a tick.
// Config is double-buffered: o_cfg_ready drops on accept and returns when the shadow is applied on a tick or i_sync.
module nco_phase_gen #(
    parameter int unsigned FW    = 32,
    parameter int unsigned PW    = 23,
    parameter int unsigned IW    = 16,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned DW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [FW-1:0]    i_freq,
    input  logic [PW-1:0]    i_phase_ofs,
    input  logic [IW-1:0]    i_amp,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_dither_en,
    output logic [PW-1:0]    o_phase,
    output logic [IW-1:0]    o_xval,
    output logic [IW-1:0]    o_yval,
    output logic             o_ce
);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    logic [FW-1:0]    acc_q, acc_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    freq_q, freq_d;
    logic [PW-1:0]    ofs_q, ofs_d;
    logic [IW-1:0]    amp_q, amp_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [FW-1:0]    sh_freq_q, sh_freq_d;
    logic [PW-1:0]    sh_ofs_q, sh_ofs_d;
    logic [IW-1:0]    sh_amp_q, sh_amp_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             pend_q, pend_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [IW-1:0]    xval_q, xval_d;
    logic [IW-1:0]    yval_q, yval_d;
    logic             ce_q, ce_d;

    logic          tick;
    logic          accept;
    logic          lfsr_fb;
    logic [PW-1:0] dith;

    assign tick    = i_en && (cnt_q == '0) && !i_sync;
    assign accept  = i_cfg_valid && !pend_q;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign dith    = i_dither_en ? {{(PW-DW){lfsr_q[DW-1]}}, lfsr_q[DW-1:0]} : '0;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        freq_d    = freq_q;
        ofs_d     = ofs_q;
        amp_d     = amp_q;
        div_d     = div_q;
        sh_freq_d = sh_freq_q;
        sh_ofs_d  = sh_ofs_q;
        sh_amp_d  = sh_amp_q;
        sh_div_d  = sh_div_q;
        pend_d    = pend_q;
        lfsr_d    = lfsr_q;
        phase_d   = phase_q;
        xval_d    = xval_q;
        yval_d    = yval_q;
        ce_d      = 1'b0;

        if (i_sync) begin
            acc_d  = '0;
            cnt_d  = '0;
            lfsr_d = LFSR_SEED;
            // A pending shadow and a fresh accept are mutually exclusive since ready is low while pending.
            if (pend_q) begin
                freq_d = sh_freq_q;
                ofs_d  = sh_ofs_q;
                amp_d  = sh_amp_q;
                div_d  = sh_div_q;
                pend_d = 1'b0;
            end else if (accept) begin
                freq_d = i_freq;
                ofs_d  = i_phase_ofs;
                amp_d  = i_amp;
                div_d  = i_div;
            end
        end else begin
            if (accept) begin
                sh_freq_d = i_freq;
                sh_ofs_d  = i_phase_ofs;
                sh_amp_d  = i_amp;
                sh_div_d  = i_div;
                pend_d    = 1'b1;
            end
            if (tick) begin
                phase_d = acc_q[FW-1 -: PW] + ofs_q + dith;
                xval_d  = amp_q;
                yval_d  = '0;
                acc_d   = acc_q + freq_q;
                ce_d    = 1'b1;
                cnt_d   = div_q;
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                // Apply on the sample boundary; the new divider takes effect on this reload.
                if (pend_q) begin
                    freq_d = sh_freq_q;
                    ofs_d  = sh_ofs_q;
                    amp_d  = sh_amp_q;
                    div_d  = sh_div_q;
                    cnt_d  = sh_div_q;
                    pend_d = 1'b0;
                end
            end else if (i_en && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            freq_q    <= '0;
            ofs_q     <= '0;
            amp_q     <= '0;
            div_q     <= '0;
            sh_freq_q <= '0;
            sh_ofs_q  <= '0;
            sh_amp_q  <= '0;
            sh_div_q  <= '0;
            pend_q    <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            phase_q   <= '0;
            xval_q    <= '0;
            yval_q    <= '0;
            ce_q      <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            freq_q    <= freq_d;
            ofs_q     <= ofs_d;
            amp_q     <= amp_d;
            div_q     <= div_d;
            sh_freq_q <= sh_freq_d;
            sh_ofs_q  <= sh_ofs_d;
            sh_amp_q  <= sh_amp_d;
            sh_div_q  <= sh_div_d;
            pend_q    <= pend_d;
            lfsr_q    <= lfsr_d;
            phase_q   <= phase_d;
            xval_q    <= xval_d;
            yval_q    <= yval_d;
            ce_q      <= ce_d;
        end
    end

    assign o_cfg_ready = !pend_q;
    assign o_phase     = phase_q;
    assign o_xval      = xval_q;
    assign o_yval      = yval_q;
    assign o_ce        = ce_q;

endmodule
